// File: rtl/down_count_timer.sv
// Loadable N-bit down-counter with one-cycle terminal-count pulse and
// optional auto-reload for periodic tick generation.
module down_count_timer #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         auto_reload,
  output logic [N-1:0] count_out,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q,  state_d;
  logic [N-1:0] count_q,  count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q,   done_d;

  logic         at_zero;
  assign at_zero = (count_q == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load) begin
      // A load from any state restarts the count and wins over terminal count.
      state_d  = ST_RUN;
      count_d  = load_val;
      reload_d = load_val;
    end else if ((state_q == ST_RUN) && en) begin
      if (at_zero) begin
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count_out = count_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Loadable N-bit down-counter/timer: the counterpart of the team's free-running up-counter, counting toward zero instead of toward all-ones.
- Software or an upstream FSM loads a start value. The block decrements on each enabled cycle and pulses done for one cycle at terminal count (zero).
- Optional auto-reload turns it into a periodic tick generator. Used as a delay/timeout source in the sequential-logic blocks.

Parameters:
- N, 3, counter width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear/abort; returns to IDLE.
- load  input  1  synchronous load strobe; captures load_val.
- load_val  input  N  start/reload value.
- en  input  1  count enable; decrement only when high.
- auto_reload  input  1  1 = reload from stored value at terminal count; 0 = one-shot.
- count_out  output  N  current count value (registered).
- busy  output  1  high while in RUN state (registered).
- done  output  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-count):
  - count_out = 0, done = 0, busy = 0, state = IDLE.
  - Internal reload register = {N{1'b1}}.
- States are IDLE (busy=0) and RUN (busy=1). All outputs are registered.
- Priority per cycle: clr > load > count/terminal logic.
- clr=1: next cycle count_out = 0, state = IDLE, done = 0. The reload register is unchanged.
- load=1 (clr=0), from any state:
  - count_out = load_val and reload register = load_val.
  - state = RUN, done = 0.
  - en is ignored in the load cycle.
  - A load during RUN restarts the count immediately.
- RUN, en=0: all registers hold, done = 0.
- RUN, en=1, count_out != 0: count_out decrements by 1, done = 0.
- RUN, en=1, count_out == 0 (terminal count): done = 1 for exactly that next cycle.
  - auto_reload=1: count_out = reload register, stay in RUN.
  - auto_reload=0: count_out stays 0, state = IDLE.
  - auto_reload is sampled in the terminal cycle only.
- IDLE: count_out holds and en is ignored. done = 0 except for the single pulse cycle immediately after terminal count.
- Latency, with load at edge k and en held high:
  - count_out = L after edge k, reaches 0 after edge k+L.
  - done is high after edge k+L+1, for one cycle.
  - Auto-reload period = L+1 enabled cycles per done pulse.
- load_val = 0: enters RUN at 0; the next enabled cycle produces done. With auto_reload=1, done pulses every enabled cycle.
- Decrement never wraps below 0; terminal detection occurs at 0 only. Width arithmetic is N-bit unsigned.
- Simultaneous load and terminal count: load wins, and no done pulse is produced.
- Simultaneous clr and load: clr wins, and the reload register is not updated.
- done is never high for two consecutive cycles unless auto_reload=1 and reload value = 0 with en held high.

Test Plan:
- Reset mid-count: N=3, load 5, count to 3, assert rst asynchronously. Required: count_out=0, busy=0, done=0 immediately; after release the block stays IDLE with en=1.
- One-shot: load_val=3, auto_reload=0, en=1. Required: count_out 3,2,1,0 on successive cycles, done=1 on the next cycle then 0, busy drops with done, count_out stays 0.
- Auto-reload: load_val=2, auto_reload=1, en=1 for 12 cycles. Required: sequence 2,1,0,2,1,0,..., with done pulsing every 3rd cycle (cycle after each 0) and busy held high.
- Enable gating: load 4, toggle en 1,0,0,1,1. Required: count_out 3,3,3,2,1; done=0 throughout.
- Priority: in RUN at count 0 with en=1, assert load with load_val=7. Required: count_out=7, no done pulse. Then assert clr and load together. Required: IDLE, count_out=0, reload still 7.
- load_val=0 with auto_reload=1, en=1. Required: done=1 every cycle after the first, count_out stays 0; full-scale load 7 gives a done period of 8 cycles.
